debug_run_ctrl: RTL and testbench

Run-control sequencer for the external debugger. It drives the program counter's `halt_active` and `reset_stages` controls, drains the pipeline on a halt request, and captures the debug PC (`dpc`). It supports single-step and redirects fetch to `dpc` on resume. The block sits between the debug module's control registers and the core's fetch stage and program counter.

---
 rtl/debug_run_ctrl.sv | 190 +++++++++++++++++++
 tb/tb_debug_run_ctrl.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/debug_run_ctrl.sv
// Debug run-control sequencer: halts/drains the pipeline, single-steps, flushes,
// and owns the debug PC that fetch is redirected to on resume.
module debug_run_ctrl #(
    parameter logic [31:0] RESET_PC      = 32'h0000_0008,
    parameter int          FLUSH_CYCLES  = 5,
    parameter int          DRAIN_TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        haltreq,
    input  logic        resumereq,
    input  logic        step_en,
    input  logic        flushreq,
    input  logic        stall,
    input  logic        retire_valid,
    input  logic [31:0] retire_next_pc,
    input  logic        pipe_empty,
    input  logic        dpc_wr_en,
    input  logic [31:0] dpc_wr_data,
    output logic        halt_active,
    output logic        reset_stages,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc,
    output logic        halted,
    output logic        resumeack,
    output logic [31:0] dpc,
    output logic [2:0]  cause
);

    typedef enum logic [2:0] {
        RUN,
        DRAIN,
        HALTED,
        STEP_ISSUE,
        STEP_WAIT,
        FLUSH
    } state_t;

    localparam int MAX_COUNT = (FLUSH_CYCLES > DRAIN_TIMEOUT) ? FLUSH_CYCLES : DRAIN_TIMEOUT;
    localparam int CW        = $clog2(MAX_COUNT + 1);

    localparam logic [CW-1:0] DRAIN_LOAD = CW'(DRAIN_TIMEOUT);
    localparam logic [CW-1:0] FLUSH_LOAD = CW'(FLUSH_CYCLES);
    localparam logic [CW-1:0] COUNT_ONE  = CW'(1);

    localparam logic [2:0] CAUSE_NONE    = 3'd0;
    localparam logic [2:0] CAUSE_HALTREQ = 3'd3;
    localparam logic [2:0] CAUSE_STEP    = 3'd4;
    localparam logic [2:0] CAUSE_TIMEOUT = 3'd5;

    state_t        state;
    state_t        state_next;
    logic [CW-1:0] count;
    logic [CW-1:0] count_next;
    logic          timeout_flush;
    logic          timeout_flush_next;
    logic          step_retired;
    logic          step_retired_next;
    logic [31:0]   dpc_next;
    logic [2:0]    cause_next;
    logic          accept;

    logic          halt_active_next;
    logic          reset_stages_next;
    logic          halted_next;
    logic          resumeack_next;

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= RUN;
            count          <= '0;
            timeout_flush  <= 1'b0;
            step_retired   <= 1'b0;
            dpc            <= RESET_PC;
            cause          <= CAUSE_NONE;
            halt_active    <= 1'b0;
            reset_stages   <= 1'b0;
            halted         <= 1'b0;
            resumeack      <= 1'b0;
            redirect_valid <= 1'b0;
        end else begin
            state          <= state_next;
            count          <= count_next;
            timeout_flush  <= timeout_flush_next;
            step_retired   <= step_retired_next;
            dpc            <= dpc_next;
            cause          <= cause_next;
            halt_active    <= halt_active_next;
            reset_stages   <= reset_stages_next;
            halted         <= halted_next;
            resumeack      <= resumeack_next;
            redirect_valid <= resumeack_next;
        end
    end

    // The shared down-counter exits DRAIN/FLUSH on the cycle it holds 1, so a load of N gives N cycles.
    always_comb begin
        state_next         = state;
        count_next         = count;
        timeout_flush_next = timeout_flush;
        step_retired_next  = step_retired;
        dpc_next           = dpc;
        cause_next         = cause;
        accept             = 1'b0;

        if (flushreq) begin
            state_next         = FLUSH;
            count_next         = FLUSH_LOAD;
            timeout_flush_next = 1'b0;
        end else begin
            case (state)
                RUN: begin
                    if (retire_valid) dpc_next = retire_next_pc;
                    if (haltreq) begin
                        state_next = DRAIN;
                        count_next = DRAIN_LOAD;
                    end
                end
                DRAIN: begin
                    if (retire_valid) dpc_next = retire_next_pc;
                    if (pipe_empty) begin
                        state_next = HALTED;
                        cause_next = CAUSE_HALTREQ;
                    end else if (count == COUNT_ONE) begin
                        state_next         = FLUSH;
                        count_next         = FLUSH_LOAD;
                        timeout_flush_next = 1'b1;
                    end else begin
                        count_next = count - COUNT_ONE;
                    end
                end
                HALTED: begin
                    if (dpc_wr_en) dpc_next = dpc_wr_data;
                    if (resumereq && !haltreq) begin
                        accept            = 1'b1;
                        cause_next        = CAUSE_NONE;
                        step_retired_next = 1'b0;
                        state_next        = step_en ? STEP_ISSUE : RUN;
                    end
                end
                STEP_ISSUE: begin
                    if (retire_valid) begin
                        dpc_next          = retire_next_pc;
                        step_retired_next = 1'b1;
                    end
                    if (!stall) state_next = STEP_WAIT;
                end
                STEP_WAIT: begin
                    if (retire_valid) begin
                        dpc_next          = retire_next_pc;
                        step_retired_next = 1'b1;
                    end
                    if (pipe_empty && (step_retired || retire_valid)) begin
                        state_next = HALTED;
                        cause_next = CAUSE_STEP;
                    end
                end
                FLUSH: begin
                    if (count == COUNT_ONE) begin
                        if (haltreq) begin
                            state_next = HALTED;
                            cause_next = timeout_flush ? CAUSE_TIMEOUT : CAUSE_HALTREQ;
                        end else begin
                            state_next = RUN;
                            cause_next = CAUSE_NONE;
                        end
                    end else begin
                        count_next = count - COUNT_ONE;
                    end
                end
                default: begin
                    state_next = RUN;
                end
            endcase
        end

        if (state_next == FLUSH) dpc_next = RESET_PC;
    end

    always_comb begin
        halt_active_next  = (state_next == DRAIN) || (state_next == HALTED) ||
                            (state_next == STEP_WAIT) || (state_next == FLUSH);
        reset_stages_next = (state_next == FLUSH);
        halted_next       = (state_next == HALTED);
        resumeack_next    = accept;
    end

    assign redirect_pc = dpc;

endmodule

// File: tb/tb_debug_run_ctrl.sv
// Self-checking bench for debug_run_ctrl: directed vector table, hand-written
// multi-cycle sequences, then random traffic against a cycle-level reference model.
module tb_debug_run_ctrl;

    localparam logic [31:0] RESET_PC      = 32'h0000_0008;
    localparam int          FLUSH_CYCLES  = 5;
    localparam int          DRAIN_TIMEOUT = 15;
    localparam int          RANDOM_CYCLES = 3000;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        haltreq = 1'b0;
    logic        resumereq = 1'b0;
    logic        step_en = 1'b0;
    logic        flushreq = 1'b0;
    logic        stall = 1'b0;
    logic        retire_valid = 1'b0;
    logic [31:0] retire_next_pc = '0;
    logic        pipe_empty = 1'b0;
    logic        dpc_wr_en = 1'b0;
    logic [31:0] dpc_wr_data = '0;
    logic        halt_active;
    logic        reset_stages;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        halted;
    logic        resumeack;
    logic [31:0] dpc;
    logic [2:0]  cause;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    debug_run_ctrl #(
        .RESET_PC     (RESET_PC),
        .FLUSH_CYCLES (FLUSH_CYCLES),
        .DRAIN_TIMEOUT(DRAIN_TIMEOUT)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .haltreq       (haltreq),
        .resumereq     (resumereq),
        .step_en       (step_en),
        .flushreq      (flushreq),
        .stall         (stall),
        .retire_valid  (retire_valid),
        .retire_next_pc(retire_next_pc),
        .pipe_empty    (pipe_empty),
        .dpc_wr_en     (dpc_wr_en),
        .dpc_wr_data   (dpc_wr_data),
        .halt_active   (halt_active),
        .reset_stages  (reset_stages),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .halted        (halted),
        .resumeack     (resumeack),
        .dpc           (dpc),
        .cause         (cause)
    );

    typedef struct {
        logic        rst, hreq, rreq, step, freq, stl, rv;
        logic [31:0] npc;
        logic        pe, we;
        logic [31:0] wd;
        logic        ha, rs, rdv, hlt, ack;
        logic [31:0] edpc;
        logic [2:0]  ecause;
    } vec_t;

    vec_t vecs[$];

    task automatic add_vec(input logic rst, hreq, rreq, step, freq, stl, rv,
                           input logic [31:0] npc, input logic pe, we, input logic [31:0] wd,
                           input logic ha, rs, rdv, hlt, ack,
                           input logic [31:0] edpc, input logic [2:0] ecause);
        vec_t v;
        v.rst = rst;  v.hreq = hreq; v.rreq = rreq; v.step = step; v.freq = freq;
        v.stl = stl;  v.rv = rv;     v.npc = npc;   v.pe = pe;     v.we = we;
        v.wd = wd;    v.ha = ha;     v.rs = rs;     v.rdv = rdv;   v.hlt = hlt;
        v.ack = ack;  v.edpc = edpc; v.ecause = ecause;
        vecs.push_back(v);
    endtask

    task automatic applyStimulus(input logic rst, hreq, rreq, step, freq, stl, rv,
                                 input logic [31:0] npc, input logic pe, we,
                                 input logic [31:0] wd);
        reset          = rst;
        haltreq        = hreq;
        resumereq      = rreq;
        step_en        = step;
        flushreq       = freq;
        stall          = stl;
        retire_valid   = rv;
        retire_next_pc = npc;
        pipe_empty     = pe;
        dpc_wr_en      = we;
        dpc_wr_data    = wd;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic ha, rs, rdv, hlt, ack,
                               input logic [31:0] edpc, input logic [2:0] ecause);
        tests++;
        if ({halt_active, reset_stages, redirect_valid, halted, resumeack} !== {ha, rs, rdv, hlt, ack} ||
            dpc !== edpc || redirect_pc !== edpc || cause !== ecause) begin
            fails++;
            $display("[TB] FAIL %s @%0t: got ha=%0b rs=%0b rdv=%0b halted=%0b ack=%0b dpc=%h rpc=%h cause=%0d, want ha=%0b rs=%0b rdv=%0b halted=%0b ack=%0b dpc=%h cause=%0d",
                     name, $time, halt_active, reset_stages, redirect_valid, halted, resumeack,
                     dpc, redirect_pc, cause, ha, rs, rdv, hlt, ack, edpc, ecause);
        end
    endtask

    // Reference model: tracks which phase of the debug protocol we are in plus elapsed/remaining cycle counts.
    typedef enum {MD_RUN, MD_DRAIN, MD_HALTED, MD_STEP_ISSUE, MD_STEP_WAIT, MD_FLUSH} mode_t;

    mode_t       m_mode = MD_RUN;
    logic [31:0] m_dpc = RESET_PC;
    logic [2:0]  m_cause = 3'd0;
    int          m_drain_age = 0;
    int          m_flush_left = 0;
    logic        m_by_timeout = 1'b0;
    logic        m_step_retired = 1'b0;
    logic        m_ack = 1'b0;

    task automatic model_enter_flush(input logic by_timeout);
        m_mode       = MD_FLUSH;
        m_flush_left = FLUSH_CYCLES;
        m_dpc        = RESET_PC;
        m_by_timeout = by_timeout;
    endtask

    task automatic model_step();
        m_ack = 1'b0;
        if (reset) begin
            m_mode  = MD_RUN;
            m_dpc   = RESET_PC;
            m_cause = 3'd0;
        end else if (flushreq) begin
            model_enter_flush(1'b0);
        end else begin
            case (m_mode)
                MD_RUN: begin
                    if (retire_valid) m_dpc = retire_next_pc;
                    if (haltreq) begin
                        m_mode      = MD_DRAIN;
                        m_drain_age = 0;
                    end
                end
                MD_DRAIN: begin
                    if (retire_valid) m_dpc = retire_next_pc;
                    m_drain_age++;
                    if (pipe_empty) begin
                        m_mode  = MD_HALTED;
                        m_cause = 3'd3;
                    end else if (m_drain_age >= DRAIN_TIMEOUT) begin
                        model_enter_flush(1'b1);
                    end
                end
                MD_HALTED: begin
                    if (dpc_wr_en) m_dpc = dpc_wr_data;
                    if (resumereq && !haltreq) begin
                        m_ack          = 1'b1;
                        m_cause        = 3'd0;
                        m_step_retired = 1'b0;
                        m_mode         = step_en ? MD_STEP_ISSUE : MD_RUN;
                    end
                end
                MD_STEP_ISSUE, MD_STEP_WAIT: begin
                    if (retire_valid) begin
                        m_dpc          = retire_next_pc;
                        m_step_retired = 1'b1;
                    end
                    if (m_mode == MD_STEP_ISSUE) begin
                        if (!stall) m_mode = MD_STEP_WAIT;
                    end else if (pipe_empty && m_step_retired) begin
                        m_mode  = MD_HALTED;
                        m_cause = 3'd4;
                    end
                end
                MD_FLUSH: begin
                    m_flush_left--;
                    if (m_flush_left == 0) begin
                        m_mode  = haltreq ? MD_HALTED : MD_RUN;
                        m_cause = haltreq ? (m_by_timeout ? 3'd5 : 3'd3) : 3'd0;
                    end
                end
                default: m_mode = MD_RUN;
            endcase
        end
    endtask

    task automatic check_model(input string name);
        checkOutput(name,
                    m_mode inside {MD_DRAIN, MD_HALTED, MD_STEP_WAIT, MD_FLUSH},
                    m_mode == MD_FLUSH, m_ack, m_mode == MD_HALTED, m_ack, m_dpc, m_cause);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation still running at %0t, required completion", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic h;

        // rst hreq rreq step freq stall rv npc pe we wd | ha rs rdv hlt ack dpc cause
        add_vec(1,0,0,0,0,0,0,32'h0,  0,0,32'h0,   0,0,0,0,0, RESET_PC, 3'd0);
        add_vec(0,0,0,0,0,0,1,32'h10, 0,0,32'h0,   0,0,0,0,0, 32'h10,   3'd0);
        add_vec(0,0,1,0,0,0,0,32'h0,  0,1,32'h55,  0,0,0,0,0, 32'h10,   3'd0);
        add_vec(0,1,0,0,0,0,0,32'h0,  0,0,32'h0,   1,0,0,0,0, 32'h10,   3'd0);
        add_vec(0,1,0,0,0,0,1,32'h20, 0,0,32'h0,   1,0,0,0,0, 32'h20,   3'd0);
        add_vec(0,1,0,0,0,0,1,32'h24, 1,0,32'h0,   1,0,0,1,0, 32'h24,   3'd3);
        add_vec(0,1,1,0,0,0,0,32'h0,  1,0,32'h0,   1,0,0,1,0, 32'h24,   3'd3);
        add_vec(0,0,1,0,0,0,0,32'h0,  1,1,32'h100, 0,0,1,0,1, 32'h100,  3'd0);
        add_vec(0,0,0,0,0,0,0,32'h0,  1,0,32'h0,   0,0,0,0,0, 32'h100,  3'd0);
        add_vec(0,1,0,0,0,0,0,32'h0,  0,0,32'h0,   1,0,0,0,0, 32'h100,  3'd0);
        add_vec(0,1,0,0,0,0,0,32'h0,  1,0,32'h0,   1,0,0,1,0, 32'h100,  3'd3);
        add_vec(0,0,1,1,0,1,0,32'h0,  1,0,32'h0,   0,0,1,0,1, 32'h100,  3'd0);
        for (int i = 0; i < 3; i++)
            add_vec(0,0,0,1,0,1,0,32'h0, 0,0,32'h0, 0,0,0,0,0, 32'h100, 3'd0);
        add_vec(0,0,0,1,0,0,0,32'h0,  0,0,32'h0,   1,0,0,0,0, 32'h100,  3'd0);
        add_vec(0,0,0,1,0,0,1,32'h104,0,0,32'h0,   1,0,0,0,0, 32'h104,  3'd0);
        add_vec(0,0,0,1,0,0,0,32'h0,  1,0,32'h0,   1,0,0,1,0, 32'h104,  3'd4);
        add_vec(0,0,1,0,1,0,0,32'h0,  0,0,32'h0,   1,1,0,0,0, RESET_PC, 3'd4);
        for (int i = 0; i < FLUSH_CYCLES - 1; i++)
            add_vec(0,0,0,0,0,0,0,32'h0, 0,0,32'h0, 1,1,0,0,0, RESET_PC, 3'd4);
        add_vec(0,0,0,0,0,0,0,32'h0,  0,0,32'h0,   0,0,0,0,0, RESET_PC, 3'd0);

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].rst, vecs[i].hreq, vecs[i].rreq, vecs[i].step, vecs[i].freq,
                          vecs[i].stl, vecs[i].rv, vecs[i].npc, vecs[i].pe, vecs[i].we, vecs[i].wd);
            tick();
            checkOutput($sformatf("vec%0d", i), vecs[i].ha, vecs[i].rs, vecs[i].rdv,
                        vecs[i].hlt, vecs[i].ack, vecs[i].edpc, vecs[i].ecause);
        end

        // Drain timeout: DRAIN_TIMEOUT cycles of drain, FLUSH_CYCLES of reset_stages, then halted.
        for (int c = 1; c <= DRAIN_TIMEOUT + FLUSH_CYCLES + 1; c++) begin
            applyStimulus(0,1,0,0,0,0,0,32'h0,0,0,32'h0);
            tick();
            if (c <= DRAIN_TIMEOUT)
                checkOutput($sformatf("timeout_drain%0d", c), 1,0,0,0,0, RESET_PC, 3'd0);
            else if (c <= DRAIN_TIMEOUT + FLUSH_CYCLES)
                checkOutput($sformatf("timeout_flush%0d", c), 1,1,0,0,0, RESET_PC, 3'd0);
            else
                checkOutput("timeout_halted", 1,0,0,1,0, RESET_PC, 3'd5);
        end

        // Step into STEP_WAIT, retire once without draining, then reset mid-step.
        applyStimulus(0,0,1,1,0,0,0,32'h0,0,0,32'h0);
        tick();
        checkOutput("step_accept", 0,0,1,0,1, RESET_PC, 3'd0);
        applyStimulus(0,0,0,1,0,0,0,32'h0,0,0,32'h0);
        tick();
        checkOutput("step_wait", 1,0,0,0,0, RESET_PC, 3'd0);
        applyStimulus(0,0,0,1,0,0,1,32'h44,0,0,32'h0);
        tick();
        checkOutput("step_wait_retire", 1,0,0,0,0, 32'h44, 3'd0);
        applyStimulus(1,1,1,1,0,1,1,32'h80,1,1,32'h90);
        tick();
        checkOutput("reset_in_step", 0,0,0,0,0, RESET_PC, 3'd0);

        applyStimulus(1,0,0,0,0,0,0,32'h0,0,0,32'h0);
        model_step();
        tick();
        check_model("rand_reset");

        h = 1'b0;
        for (int c = 0; c < RANDOM_CYCLES; c++) begin
            if ($urandom_range(9) == 0) h = ~h;
            applyStimulus($urandom_range(299) == 0, h,
                          $urandom_range(3) == 0, $urandom_range(1) == 1,
                          $urandom_range(59) == 0, $urandom_range(2) == 0,
                          $urandom_range(2) == 0, $urandom() & 32'hFFFF_FFFC,
                          $urandom_range(7) == 0, $urandom_range(3) == 0,
                          $urandom() & 32'hFFFF_FFFC);
            model_step();
            tick();
            check_model($sformatf("rand%0d", c));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
